// File: rtl/scnn_coord_gen.sv
// SCNN PE output-coordinate generator: decodes one chunk of zero-run index deltas, splits the
// indices into row/col with an iterative subtractor, then streams F_VEC beats of I_VEC coordinates.
// Optional macro SCNN_OOB_SENTINEL_EN: out-of-bounds lanes drive all-ones instead of zero.
module scnn_coord_gen #(
    parameter int unsigned F_VEC = 4,
    parameter int unsigned I_VEC = 4,
    parameter int unsigned IDX_W = 8,
    parameter int unsigned DIM_W = 5
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [F_VEC*IDX_W-1:0]        comp_wt_ind,
    input  logic [I_VEC*IDX_W-1:0]        comp_ip_ind,
    input  logic [IDX_W-1:0]              offset_wt,
    input  logic [IDX_W-1:0]              offset_ip,
    input  logic [DIM_W-1:0]              wt_size,
    input  logic [DIM_W-1:0]              ip_size,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [((F_VEC > 1) ? $clog2(F_VEC) : 1)-1:0] out_f_idx,
    output logic [I_VEC*IDX_W-1:0]        out_cords,
    output logic [I_VEC-1:0]              out_mask,
    output logic                          out_last,
    output logic [IDX_W-1:0]              last_ind_wts,
    output logic [IDX_W-1:0]              last_ind_ips,
    output logic                          busy
);

    localparam int unsigned FW = (F_VEC > 1) ? $clog2(F_VEC) : 1;
    localparam int unsigned SW = DIM_W + 2;
    localparam int unsigned CW = (IDX_W > DIM_W) ? IDX_W : DIM_W;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DECODE = 2'd1;
    localparam logic [1:0] S_SPLIT  = 2'd2;
    localparam logic [1:0] S_EMIT   = 2'd3;

`ifdef SCNN_OOB_SENTINEL_EN
    localparam logic [IDX_W-1:0] OOB_CORD = '1;
`else
    localparam logic [IDX_W-1:0] OOB_CORD = '0;
`endif

    logic [1:0]               state, state_nxt;

    logic [F_VEC*IDX_W-1:0]   comp_wt_q;
    logic [I_VEC*IDX_W-1:0]   comp_ip_q;
    logic [IDX_W-1:0]         off_wt_q, off_ip_q;
    logic [DIM_W-1:0]         wt_size_q, ip_size_q;

    logic [IDX_W-1:0]         wt_rem [F_VEC];
    logic [IDX_W-1:0]         wt_quot[F_VEC];
    logic [IDX_W-1:0]         ip_rem [I_VEC];
    logic [IDX_W-1:0]         ip_quot[I_VEC];

    logic [IDX_W-1:0]         orig_wt_c[F_VEC];
    logic [IDX_W-1:0]         orig_ip_c[I_VEC];
    logic [IDX_W-1:0]         acc_wt_c, acc_ip_c;
    logic [F_VEC-1:0]         wt_hit_c;
    logic [I_VEC-1:0]         ip_hit_c;
    logic                     any_hit_c;
    logic                     zero_sz_c;

    logic                     accept_c, fire_c, load_beat_c, done_c;
    logic [FW-1:0]            f_sel_c;
    logic [SW-1:0]            cen_c, r_c, c_c;
    logic [IDX_W-1:0]         prod_c;
    logic                     inb_c;
    logic [I_VEC*IDX_W-1:0]   beat_cords_c;
    logic [I_VEC-1:0]         beat_mask_c;

    assign accept_c  = in_valid & in_ready;
    assign fire_c    = out_valid & out_ready;
    assign zero_sz_c = (wt_size_q == '0) || (ip_size_q == '0);

    // Running-sum decode of zero-run deltas; starting at offset-1 makes every lane add delta+1.
    always_comb begin
        acc_wt_c = off_wt_q - IDX_W'(1);
        acc_ip_c = off_ip_q - IDX_W'(1);
        for (int k = 0; k < F_VEC; k++) begin
            acc_wt_c     = acc_wt_c + comp_wt_q[k*IDX_W +: IDX_W] + IDX_W'(1);
            orig_wt_c[k] = acc_wt_c;
        end
        for (int k = 0; k < I_VEC; k++) begin
            acc_ip_c     = acc_ip_c + comp_ip_q[k*IDX_W +: IDX_W] + IDX_W'(1);
            orig_ip_c[k] = acc_ip_c;
        end
    end

    always_comb begin
        wt_hit_c = '0;
        ip_hit_c = '0;
        for (int k = 0; k < F_VEC; k++)
            wt_hit_c[k] = CW'(wt_rem[k]) >= CW'(wt_size_q);
        for (int k = 0; k < I_VEC; k++)
            ip_hit_c[k] = CW'(ip_rem[k]) >= CW'(ip_size_q);
        any_hit_c = (|wt_hit_c) | (|ip_hit_c);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (accept_c) state_nxt = S_DECODE;
            S_DECODE: state_nxt = zero_sz_c ? S_EMIT : S_SPLIT;
            S_SPLIT:  if (!any_hit_c) state_nxt = S_EMIT;
            S_EMIT:   if (fire_c && out_last) state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    assign load_beat_c = ((state != S_EMIT) && (state_nxt == S_EMIT)) ||
                         ((state == S_EMIT) && fire_c && !out_last);
    assign done_c      = (state == S_EMIT) && fire_c && out_last;

    // Coordinates of the beat about to be presented: beat 0 on entry, else the next weight lane.
    always_comb begin
        f_sel_c      = (state == S_EMIT) ? out_f_idx + FW'(1) : '0;
        cen_c        = (SW'(wt_size_q) - SW'(1)) >> 1;
        r_c          = '0;
        c_c          = '0;
        prod_c       = '0;
        inb_c        = 1'b0;
        beat_cords_c = '0;
        beat_mask_c  = '0;
        for (int i = 0; i < I_VEC; i++) begin
            r_c    = SW'(ip_quot[i]) + cen_c - SW'(wt_quot[f_sel_c]);
            c_c    = SW'(ip_rem[i])  + cen_c - SW'(wt_rem[f_sel_c]);
            inb_c  = !zero_sz_c && !r_c[SW-1] && !c_c[SW-1] &&
                     (r_c < SW'(ip_size_q)) && (c_c < SW'(ip_size_q));
            prod_c = IDX_W'(r_c) * IDX_W'(ip_size_q) + IDX_W'(c_c);
            beat_mask_c[i]                 = inb_c;
            beat_cords_c[i*IDX_W +: IDX_W] = inb_c ? prod_c : OOB_CORD;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready     <= 1'b1;
            busy         <= 1'b0;
            out_valid    <= 1'b0;
            out_last     <= 1'b0;
            out_f_idx    <= '0;
            out_cords    <= '0;
            out_mask     <= '0;
            last_ind_wts <= '0;
            last_ind_ips <= '0;
            comp_wt_q    <= '0;
            comp_ip_q    <= '0;
            off_wt_q     <= '0;
            off_ip_q     <= '0;
            wt_size_q    <= '0;
            ip_size_q    <= '0;
            for (int k = 0; k < F_VEC; k++) begin
                wt_rem[k]  <= '0;
                wt_quot[k] <= '0;
            end
            for (int k = 0; k < I_VEC; k++) begin
                ip_rem[k]  <= '0;
                ip_quot[k] <= '0;
            end
        end else begin
            in_ready  <= (state_nxt == S_IDLE);
            busy      <= (state_nxt != S_IDLE);
            out_valid <= (state_nxt == S_EMIT);

            if (accept_c) begin
                comp_wt_q <= comp_wt_ind;
                comp_ip_q <= comp_ip_ind;
                off_wt_q  <= offset_wt;
                off_ip_q  <= offset_ip;
                wt_size_q <= wt_size;
                ip_size_q <= ip_size;
            end

            if (state == S_DECODE) begin
                last_ind_wts <= orig_wt_c[F_VEC-1];
                last_ind_ips <= orig_ip_c[I_VEC-1];
                for (int k = 0; k < F_VEC; k++) begin
                    wt_rem[k]  <= orig_wt_c[k];
                    wt_quot[k] <= '0;
                end
                for (int k = 0; k < I_VEC; k++) begin
                    ip_rem[k]  <= orig_ip_c[k];
                    ip_quot[k] <= '0;
                end
            end

            // One subtract-and-count step per qualifying lane per cycle.
            if (state == S_SPLIT) begin
                for (int k = 0; k < F_VEC; k++) begin
                    if (wt_hit_c[k]) begin
                        wt_rem[k]  <= wt_rem[k] - IDX_W'(wt_size_q);
                        wt_quot[k] <= wt_quot[k] + IDX_W'(1);
                    end
                end
                for (int k = 0; k < I_VEC; k++) begin
                    if (ip_hit_c[k]) begin
                        ip_rem[k]  <= ip_rem[k] - IDX_W'(ip_size_q);
                        ip_quot[k] <= ip_quot[k] + IDX_W'(1);
                    end
                end
            end

            if (load_beat_c) begin
                out_f_idx <= f_sel_c;
                out_cords <= beat_cords_c;
                out_mask  <= beat_mask_c;
                out_last  <= (f_sel_c == FW'(F_VEC - 1));
            end else if (done_c) begin
                out_last  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_scnn_coord_gen.sv
// Directed self-checking bench for scnn_coord_gen (F_VEC=I_VEC=4, IDX_W=8, DIM_W=5).
module tb_scnn_coord_gen;

`ifdef SCNN_OOB_SENTINEL_EN
    localparam logic [7:0] O = 8'hFF;
`else
    localparam logic [7:0] O = 8'h00;
`endif

    logic        clk, rst_n;
    logic        in_valid, in_ready;
    logic [31:0] comp_wt_ind, comp_ip_ind;
    logic [7:0]  offset_wt, offset_ip;
    logic [4:0]  wt_size, ip_size;
    logic        out_valid, out_ready;
    logic [1:0]  out_f_idx;
    logic [31:0] out_cords;
    logic [3:0]  out_mask;
    logic        out_last;
    logic [7:0]  last_ind_wts, last_ind_ips;
    logic        busy;

    int vecs = 0;
    int errs = 0;
    logic [31:0] exp_c[4];
    logic [3:0]  exp_m[4];

    scnn_coord_gen #(.F_VEC(4), .I_VEC(4), .IDX_W(8), .DIM_W(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .comp_wt_ind(comp_wt_ind), .comp_ip_ind(comp_ip_ind),
        .offset_wt(offset_wt), .offset_ip(offset_ip),
        .wt_size(wt_size), .ip_size(ip_size),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_f_idx(out_f_idx), .out_cords(out_cords), .out_mask(out_mask),
        .out_last(out_last),
        .last_ind_wts(last_ind_wts), .last_ind_ips(last_ind_ips),
        .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // 3x3 filter over 4x4 plane, indices 0..3 on both sides.
    task automatic set_exp_basic();
        exp_c[0] = {O, 8'd7, 8'd6, 8'd5};    exp_m[0] = 4'b0111;
        exp_c[1] = {8'd7, 8'd6, 8'd5, 8'd4}; exp_m[1] = 4'b1111;
        exp_c[2] = {8'd6, 8'd5, 8'd4, O};    exp_m[2] = 4'b1110;
        exp_c[3] = {O, 8'd3, 8'd2, 8'd1};    exp_m[3] = 4'b0111;
    endtask

    task automatic send(input logic [7:0] ow, input logic [7:0] oi, input logic [31:0] cw,
                        input logic [31:0] ci, input logic [4:0] ws, input logic [4:0] is);
        chk("in_ready_idle", 32'(in_ready), 32'd1);
        offset_wt = ow; offset_ip = oi; comp_wt_ind = cw; comp_ip_ind = ci;
        wt_size = ws; ip_size = is; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("busy_after_accept", 32'(busy), 32'd1);
        chk("in_ready_after_accept", 32'(in_ready), 32'd0);
    endtask

    // Called in the cycle after accept (T+1); reports k where out_valid first rises at T+k.
    task automatic wait_valid(input int exp_n);
        int n = 0;
        for (int k = 1; k <= 40; k++) begin
            if (out_valid) begin
                n = k;
                break;
            end
            step();
        end
        chk("first_valid_latency", 32'(n), 32'(exp_n));
    endtask

    task automatic drain_beats();
        out_ready = 1'b1;
        for (int b = 0; b < 4; b++) begin
            chk($sformatf("beat%0d_valid", b), 32'(out_valid), 32'd1);
            chk($sformatf("beat%0d_f_idx", b), 32'(out_f_idx), 32'(b));
            chk($sformatf("beat%0d_cords", b), out_cords, exp_c[b]);
            chk($sformatf("beat%0d_mask", b), 32'(out_mask), 32'(exp_m[b]));
            chk($sformatf("beat%0d_last", b), 32'(out_last), (b == 3) ? 32'd1 : 32'd0);
            step();
        end
        chk("post_chunk_valid", 32'(out_valid), 32'd0);
        chk("post_chunk_in_ready", 32'(in_ready), 32'd1);
        chk("post_chunk_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        logic [3:0] pat;
        int nb;
        int b;
        clk = 1'b0; rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        comp_wt_ind = '0; comp_ip_ind = '0; offset_wt = '0; offset_ip = '0;
        wt_size = '0; ip_size = '0;

        // Reset values
        #2 rst_n = 1'b0;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_last", 32'(out_last), 32'd0);
        chk("rst_f_idx", 32'(out_f_idx), 32'd0);
        chk("rst_cords", out_cords, 32'd0);
        chk("rst_mask", 32'(out_mask), 32'd0);
        chk("rst_last_wts", 32'(last_ind_wts), 32'd0);
        chk("rst_last_ips", 32'(last_ind_ips), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Basic chunk, continuous out_ready
        set_exp_basic();
        send(8'd0, 8'd0, 32'd0, 32'd0, 5'd3, 5'd4);
        wait_valid(4);
        drain_beats();
        chk("basic_last_wts", 32'(last_ind_wts), 32'd3);
        chk("basic_last_ips", 32'(last_ind_ips), 32'd3);

        // Offsets and deltas: wt 1,2,3,4; ip 7,8,10,11 (q_max 2)
        send(8'd0, 8'd5, 32'h0000_0001, 32'h0001_0002, 5'd3, 5'd4);
        wait_valid(5);
        nb = 0;
        for (int k = 0; k < 20; k++) begin
            if (out_valid && nb == 0) begin
                chk("decode_beat0_cords", out_cords, 32'h0F0E_0C0B);
                chk("decode_beat0_mask", 32'(out_mask), 32'hF);
            end
            if (out_valid) nb++;
            if (out_valid && out_last) begin
                chk("decode_beat3_cords", out_cords, 32'h0B0A_0807);
                step();
                break;
            end
            step();
        end
        chk("decode_beats", 32'(nb), 32'd4);
        chk("decode_last_wts", 32'(last_ind_wts), 32'd4);
        chk("decode_last_ips", 32'(last_ind_ips), 32'd11);
        chk("decode_in_ready", 32'(in_ready), 32'd1);

        // Backpressure: out_ready 1,0,0,1 per cycle
        set_exp_basic();
        send(8'd0, 8'd0, 32'd0, 32'd0, 5'd3, 5'd4);
        wait_valid(4);
        pat = 4'b1001;
        b = 0;
        for (int c = 0; c < 40 && b < 4; c++) begin
            out_ready = pat[c % 4];
            chk($sformatf("bp_c%0d_valid", c), 32'(out_valid), 32'd1);
            chk($sformatf("bp_c%0d_f_idx", c), 32'(out_f_idx), 32'(b));
            chk($sformatf("bp_c%0d_cords", c), out_cords, exp_c[b]);
            chk($sformatf("bp_c%0d_mask", c), 32'(out_mask), 32'(exp_m[b]));
            chk($sformatf("bp_c%0d_last", c), 32'(out_last), (b == 3) ? 32'd1 : 32'd0);
            if (out_ready) b++;
            step();
        end
        out_ready = 1'b1;
        chk("bp_beats", 32'(b), 32'd4);
        chk("bp_post_valid", 32'(out_valid), 32'd0);
        chk("bp_post_in_ready", 32'(in_ready), 32'd1);

        // Zero input plane size: straight to EMIT, everything masked
        for (int i = 0; i < 4; i++) begin
            exp_c[i] = {O, O, O, O};
            exp_m[i] = 4'b0000;
        end
        send(8'd0, 8'd0, 32'd0, 32'd0, 5'd3, 5'd0);
        wait_valid(2);
        drain_beats();

        // Reset while in SPLIT drops the chunk
        send(8'd0, 8'd5, 32'h0000_0001, 32'h0001_0002, 5'd3, 5'd4);
        step();
        chk("split_busy", 32'(busy), 32'd1);
        chk("split_valid", 32'(out_valid), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_last_wts", 32'(last_ind_wts), 32'd0);
        chk("midrst_last_ips", 32'(last_ind_ips), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        set_exp_basic();
        send(8'd0, 8'd0, 32'd0, 32'd0, 5'd3, 5'd4);
        wait_valid(4);
        drain_beats();
        chk("after_rst_last_wts", 32'(last_ind_wts), 32'd3);
        chk("after_rst_last_ips", 32'(last_ind_ips), 32'd3);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
